lp_clk_gate_ctrl: RTL and testbench

Low-power clock-gating controller for the clock supplied by `clock_gen`. It arbitrates clock-on requests from `NUM_REQ` requesters through a 4-phase req/ack handshake and drives a single registered gate enable. It sequences the gated clock through a wake-up settling interval and an idle hysteresis interval before gating it off. It sits between the clock source and the gated domains in the low-power subsystem.

---
 rtl/lp_pkg.sv | 17 +
 rtl/lp_dn_cnt.sv | 25 ++
 rtl/lp_clk_gate_ctrl.sv | 112 +++++++++++
 tb/tb_lp_clk_gate_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/lp_pkg.sv
// Shared types and constants for the low-power clock-gating controller.
package lp_pkg;

  localparam int LP_STATE_W = 2;

  typedef enum logic [LP_STATE_W-1:0] {
    LP_OFF  = 2'd0,
    LP_WAKE = 2'd1,
    LP_ON   = 2'd2,
    LP_IDLE = 2'd3
  } lp_gate_state_e;

  function automatic int lp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lp_dn_cnt.sv
// Loadable down-counter that saturates at zero; shared by the wake and idle intervals.
module lp_dn_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lp_clk_gate_ctrl.sv
// Clock-gate sequencer: OFF -> WAKE (settle) -> ON -> IDLE (hysteresis) -> OFF,
// with a 4-phase req/ack per requester and registered outputs only.
module lp_clk_gate_ctrl
  import lp_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WAKE_CYC = 4,
  parameter int IDLE_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  force_on,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  clk_en,
  output logic [LP_STATE_W-1:0] state_o
);

  localparam int CW = $clog2(lp_max(WAKE_CYC, IDLE_CYC) + 1);
  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYC - 1);

  lp_gate_state_e     state, state_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic               clk_en_nxt;
  logic               demand;
  logic               cnt_clr, cnt_ld, cnt_dec, cnt_zero;
  logic [CW-1:0]      cnt_ld_val;

  assign demand = (|req) | force_on;

  lp_dn_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt  = state;
    ack_nxt    = '0;
    cnt_clr    = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    cnt_dec    = 1'b0;
    case (state)
      LP_OFF: begin
        if (demand) begin
          state_nxt  = LP_WAKE;
          cnt_ld     = 1'b1;
          cnt_ld_val = WAKE_LD;
        end
      end
      LP_WAKE: begin
        // Settling runs to completion even if demand vanishes meanwhile.
        if (cnt_zero) begin
          state_nxt = LP_ON;
          ack_nxt   = req;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      LP_ON: begin
        if (demand) begin
          ack_nxt = req;
        end else begin
          state_nxt  = LP_IDLE;
          cnt_ld     = 1'b1;
          cnt_ld_val = IDLE_LD;
        end
      end
      LP_IDLE: begin
        // Fresh demand beats the terminal count on the same edge.
        if (demand) begin
          state_nxt = LP_ON;
          ack_nxt   = req;
          cnt_clr   = 1'b1;
        end else if (cnt_zero) begin
          state_nxt = LP_OFF;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = LP_OFF;
    endcase
  end

  assign clk_en_nxt = (state_nxt != LP_OFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LP_OFF;
      clk_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      clk_en <= clk_en_nxt;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ack
    always_ff @(posedge clk or posedge rst) begin
      if (rst) ack[g] <= 1'b0;
      else     ack[g] <= ack_nxt[g];
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_lp_clk_gate_ctrl.sv
// Directed bench for lp_clk_gate_ctrl with default parameters (4 req, wake 4, idle 8).
module tb_lp_clk_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       force_on = 1'b0;
  logic [3:0] ack;
  logic       clk_en;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  lp_clk_gate_ctrl #(.NUM_REQ(4), .WAKE_CYC(4), .IDLE_CYC(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .force_on (force_on),
    .ack      (ack),
    .clk_en   (clk_en),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic en, input logic [3:0] a);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".clk_en"}, 32'(clk_en), 32'(en));
    chk({tag, ".ack"}, 32'(ack), 32'(a));
  endtask

  // From ON with no demand: enter IDLE, hold 7 more edges, gate off on the 8th.
  task automatic drain(input string tag);
    req = '0; force_on = 1'b0;
    tick(); chk_all({tag, ".idle"}, 2'd3, 1'b1, 4'b0);
    for (int i = 1; i <= 7; i++) begin
      tick(); chk({tag, ".hold_en"}, 32'(clk_en), 32'd1);
    end
    tick(); chk_all({tag, ".off"}, 2'd0, 1'b0, 4'b0);
  endtask

  initial begin
    tick(); tick();
    chk_all("reset", 2'd0, 1'b0, 4'b0);
    rst = 1'b0;

    // Wake from OFF
    req = 4'b0001;
    tick(); chk_all("wake.e0", 2'd1, 1'b1, 4'b0);
    tick(); tick(); tick();
    chk_all("wake.e3", 2'd1, 1'b1, 4'b0);
    tick(); chk_all("wake.e4", 2'd2, 1'b1, 4'b0001);
    tick(); chk_all("on.hold", 2'd2, 1'b1, 4'b0001);

    drain("rel");

    // Re-request three cycles into IDLE
    req = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    chk_all("rewake", 2'd2, 1'b1, 4'b0001);
    req = '0;
    tick(); chk_all("reidle", 2'd3, 1'b1, 4'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("reidle.en", 32'(clk_en), 32'd1);
    end
    req = 4'b0100;
    tick(); chk_all("rereq", 2'd2, 1'b1, 4'b0100);

    // Request arrives on the IDLE terminal edge
    req = '0;
    tick(); chk_all("coll.idle", 2'd3, 1'b1, 4'b0);
    for (int i = 0; i < 7; i++) tick();
    chk_all("coll.e7", 2'd3, 1'b1, 4'b0);
    req = 4'b0010;
    tick(); chk_all("coll.term", 2'd2, 1'b1, 4'b0010);

    drain("coll");

    // Software override: clock on without any ack
    force_on = 1'b1;
    tick(); chk_all("frc.e0", 2'd1, 1'b1, 4'b0);
    for (int i = 1; i <= 3; i++) begin
      tick(); chk_all("frc.wake", 2'd1, 1'b1, 4'b0);
    end
    tick(); chk_all("frc.e4", 2'd2, 1'b1, 4'b0);
    tick(); chk_all("frc.on", 2'd2, 1'b1, 4'b0);
    drain("frc");

    // Async reset mid-WAKE, between edges
    req = 4'b0001;
    tick(); tick();
    chk_all("ar.wake", 2'd1, 1'b1, 4'b0);
    #2 rst = 1'b1;
    #1 chk_all("ar.wake_rst", 2'd0, 1'b0, 4'b0);
    tick();
    rst = 1'b0;
    tick(); chk_all("ar.re_e0", 2'd1, 1'b1, 4'b0);
    tick(); tick(); tick();
    chk_all("ar.re_e3", 2'd1, 1'b1, 4'b0);
    tick(); chk_all("ar.re_e4", 2'd2, 1'b1, 4'b0001);
    #2 rst = 1'b1;
    #1 chk_all("ar.on_rst", 2'd0, 1'b0, 4'b0);
    tick();
    rst = 1'b0;
    req = '0;
    tick(); chk_all("ar.quiet", 2'd0, 1'b0, 4'b0);

    // Req withdrawn during WAKE: sequence still runs WAKE -> ON -> IDLE
    req = 4'b1000;
    tick(); chk_all("viol.e0", 2'd1, 1'b1, 4'b0);
    req = '0;
    tick(); tick(); tick();
    tick(); chk_all("viol.on", 2'd2, 1'b1, 4'b0);
    tick(); chk_all("viol.idle", 2'd3, 1'b1, 4'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
